// File: rtl/apb_states.sv
// Shared APB definitions: FSM state encoding and the command record, used by master and slave.
package apb_states;

    localparam int unsigned APB_DATA_W = 8;
    localparam int unsigned APB_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS wait-state counter; only built when APB_TIMEOUT_EN is defined.
// expired_o flags the wait cycle whose increment reaches limit_i.
`ifdef APB_TIMEOUT_EN
module apb_timeout_ctr #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired_o = inc_i && (cnt_q >= (limit_i - 1'b1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/apb_master.sv
// APB requester: one valid/ready command in, one registered response pulse out.
// Optional ACCESS timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master
    import apb_states::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // state  | meaning
    // IDLE   | ready for a command, bus deselected
    // SETUP  | PSELx high, PENABLE low, one cycle
    // ACCESS | PSELx and PENABLE high until PREADY (or timeout)
    apb_state_t            state_q, state_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  timeout_expired;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    apb_timeout_ctr #(
        .CNT_W(CNT_W)
    ) u_timeout (
        .clk_i    (PCLK),
        .rst_i    (PRESET),
        .clear_i  (state_q == SETUP),
        .inc_i    ((state_q == ACCESS) && !PREADY),
        .limit_i  (CNT_W'(TIMEOUT_CYCLES)),
        .expired_o(timeout_expired)
    );
`else
    // Without the timeout the limit has no effect.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_expired    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
                end else if (timeout_expired) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Reset is IDLE, so the explicit PRESET term keeps cmd_ready low while it is held.
    assign cmd_ready = (state_q == IDLE) && !PRESET;
    assign PSELx     = (state_q != IDLE);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: stimulus pushes expected responses, a monitor pops on rsp_valid.
// The timeout scenario is exercised only when APB_TIMEOUT_EN is defined.
module tb_apb_master;
    import apb_states::*;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       PSELx, PENABLE, PWRITE;
    logic [3:0] PADDR;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR;

    apb_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // slave model knobs
    int         slv_wait  = 0;
    bit         slv_err   = 1'b0;
    bit         slv_ovr   = 1'b0;
    logic [7:0] slv_rdata = 8'h00;
    logic [7:0] mem [16];
    int         wcnt      = 0;
    int         psel_cnt  = 0;
    int         pen_cnt   = 0;
    logic [3:0] paddr_setup = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge PCLK);
            if (!PRESET && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual rdata=%0h err=%0b expected no response at %0t",
                             rsp_rdata, rsp_err, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, e.rdata});
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                end
            end
        end
    end

    initial begin : slave
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                wcnt = 0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h00;
            end else if (PSELx && !PENABLE) begin
                psel_cnt++;
                paddr_setup = PADDR;
                wcnt = 0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h00;
            end else if (PSELx && PENABLE) begin
                psel_cnt++;
                pen_cnt++;
                chk("paddr_stable", {28'h0, PADDR}, {28'h0, paddr_setup});
                if (wcnt >= slv_wait) begin
                    PREADY  = 1'b1;
                    PSLVERR = slv_err;
                    PRDATA  = slv_ovr ? slv_rdata : mem[PADDR];
                    if (PWRITE && !slv_err) mem[PADDR] = PWDATA;
                end else begin
                    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h00;
                end
                wcnt++;
            end else begin
                PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h00;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input apb_cmd_t c, input logic [7:0] er, input logic ee, output bit rsp_at_accept);
        int n;
        rsp_t r;
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        r.rdata = er;
        r.err   = ee;
        exp_q.push_back(r);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        chk("cmd_accepted", {31'h0, cmd_ready}, 32'h1);
        rsp_at_accept = rsp_valid;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        chk("rsp_drained", exp_q.size(), 32'h0);
        @(negedge PCLK);
    endtask

    task automatic clr_cnt();
        psel_cnt = 0;
        pen_cnt  = 0;
    endtask

    task automatic measure_latency(input string name, input int exp_lat);
        int lat;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge PCLK);
            lat++;
        end
        chk(name, lat, exp_lat);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit seen;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 8'h00;
        repeat (2) @(negedge PCLK);

        // reset state
        chk("rst_psel", {31'h0, PSELx}, 32'h0);
        chk("rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_pwrite", {31'h0, PWRITE}, 32'h0);
        chk("rst_paddr", {28'h0, PADDR}, 32'h0);
        chk("rst_pwdata", {24'h0, PWDATA}, 32'h0);
        chk("rst_rsp_rdata", {24'h0, rsp_rdata}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        // 1: zero-wait write
        slv_wait = 0; slv_err = 1'b0; slv_ovr = 1'b0;
        clr_cnt();
        issue('{write: 1'b1, addr: 4'h3, wdata: 8'hA5}, 8'h00, 1'b0, seen);
        measure_latency("wr_latency", 3);
        wait_rsp();
        chk("wr_psel_cycles", psel_cnt, 2);
        chk("wr_penable_cycles", pen_cnt, 1);
        chk("wr_paddr", {28'h0, PADDR}, 32'h3);
        chk("wr_pwdata", {24'h0, PWDATA}, 32'hA5);
        chk("wr_pwrite", {31'h0, PWRITE}, 32'h1);

        // 2: read with 3 wait states
        slv_wait = 3; slv_ovr = 1'b1; slv_rdata = 8'h3C;
        clr_cnt();
        issue('{write: 1'b0, addr: 4'h7, wdata: 8'hEE}, 8'h3C, 1'b0, seen);
        measure_latency("rd_wait_latency", 6);
        wait_rsp();
        chk("rd_penable_cycles", pen_cnt, 4);
        chk("rd_psel_cycles", psel_cnt, 5);
        chk("rd_paddr", {28'h0, PADDR}, 32'h7);
        chk("rd_pwdata_zero", {24'h0, PWDATA}, 32'h0);
        chk("rd_pwrite", {31'h0, PWRITE}, 32'h0);

        // 3: slave error on read
        slv_wait = 0; slv_err = 1'b1; slv_ovr = 1'b1; slv_rdata = 8'hFF;
        clr_cnt();
        issue('{write: 1'b0, addr: 4'hF, wdata: 8'h00}, 8'h00, 1'b1, seen);
        wait_rsp();
        chk("err_penable_cycles", pen_cnt, 1);
        slv_err = 1'b0; slv_ovr = 1'b0;

        // 4: back-to-back write then read of the same address
        clr_cnt();
        issue('{write: 1'b1, addr: 4'h1, wdata: 8'h11}, 8'h00, 1'b0, seen);
        issue('{write: 1'b0, addr: 4'h1, wdata: 8'h00}, 8'h11, 1'b0, seen);
        chk("b2b_accept_on_rsp", {31'h0, seen}, 32'h1);
        wait_rsp();
        chk("b2b_psel_cycles", psel_cnt, 4);
        chk("b2b_penable_cycles", pen_cnt, 2);

        // 5: reset during a wait state
        slv_wait = 1000;
        issue('{write: 1'b1, addr: 4'h2, wdata: 8'h99}, 8'h00, 1'b0, seen);
        repeat (3) @(negedge PCLK);
        chk("pre_rst_in_access", {31'h0, PENABLE}, 32'h1);
        #1 PRESET = 1'b1;
        #1;
        chk("arst_psel", {31'h0, PSELx}, 32'h0);
        chk("arst_penable", {31'h0, PENABLE}, 32'h0);
        chk("arst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        chk("arst_pwrite", {31'h0, PWRITE}, 32'h0);
        chk("arst_paddr", {28'h0, PADDR}, 32'h0);
        chk("arst_pwdata", {24'h0, PWDATA}, 32'h0);
        chk("arst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        exp_q.delete();
        repeat (2) @(negedge PCLK);
        PRESET   = 1'b0;
        slv_wait = 0;
        @(negedge PCLK);
        issue('{write: 1'b1, addr: 4'h5, wdata: 8'h5A}, 8'h00, 1'b0, seen);
        wait_rsp();
        issue('{write: 1'b0, addr: 4'h5, wdata: 8'h00}, 8'h5A, 1'b0, seen);
        wait_rsp();

`ifdef APB_TIMEOUT_EN
        // 6: PREADY stuck low, then PREADY arriving on the limit cycle
        slv_wait = 1000;
        clr_cnt();
        issue('{write: 1'b0, addr: 4'h9, wdata: 8'h00}, 8'h00, 1'b1, seen);
        wait_rsp();
        chk("to_penable_cycles", pen_cnt, 16);
        chk("to_psel_cycles", psel_cnt, 17);
        chk("to_psel_dropped", {31'h0, PSELx}, 32'h0);
        slv_wait = 15; slv_ovr = 1'b1; slv_rdata = 8'h77;
        clr_cnt();
        issue('{write: 1'b0, addr: 4'h9, wdata: 8'h00}, 8'h77, 1'b0, seen);
        wait_rsp();
        chk("to_limit_pready_wins", pen_cnt, 16);
        slv_wait = 0; slv_ovr = 1'b0;
`endif

        repeat (3) @(negedge PCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
